// File: rtl/fp_frame_max.sv
// rtl/fp_frame_max.sv - per-frame float maximum/index tracker driving a registered comparator
// Define FP_FRAME_MAX_MIN_EN to also track the frame minimum (out_min/out_min_idx).
module fp_frame_max #(
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic             cmp_aeb,
  input  logic             cmp_agb,
  input  logic             cmp_alb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_err
`ifdef FP_FRAME_MAX_MIN_EN
  ,
  output logic [31:0]      out_min,
  output logic [IDX_W-1:0] out_min_idx
`endif
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    ST_ACCEPT,
    ST_WAIT,
    ST_EVAL,
    ST_WAIT_MIN,
    ST_EVAL_MIN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   sidx_q, sidx_d;
  logic [31:0]        max_q, max_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [31:0]        cmp_a_q, cmp_a_d;
  logic [31:0]        cmp_b_q, cmp_b_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef FP_FRAME_MAX_MIN_EN
  logic [31:0]        min_q, min_d;
  logic [IDX_W-1:0]   min_idx_q, min_idx_d;
`endif

  logic [2:0] flags;
  logic       flags_ok;
  logic       frame_full;

  assign flags      = {cmp_aeb, cmp_agb, cmp_alb};
  assign flags_ok   = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign frame_full = (cnt_q == CNT_W'(FRAME_LEN));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sidx_d    = sidx_q;
    max_d     = max_q;
    idx_d     = idx_q;
    err_d     = err_q;
    cmp_a_d   = cmp_a_q;
    cmp_b_d   = cmp_b_q;
`ifdef FP_FRAME_MAX_MIN_EN
    min_d     = min_q;
    min_idx_d = min_idx_q;
`endif
    case (state_q)
      ST_ACCEPT: begin
        // in_ready_q gates the accept so nothing is taken in the cycle reset releases
        if (in_valid && in_ready_q) begin
          if (cnt_q == '0) begin
            max_d = in_data;
            idx_d = '0;
`ifdef FP_FRAME_MAX_MIN_EN
            min_d     = in_data;
            min_idx_d = '0;
`endif
            cnt_d = CNT_W'(1);
            if (FRAME_LEN == 1) state_d = ST_DONE;
          end else begin
            cmp_a_d = in_data;
            cmp_b_d = max_q;
            sidx_d  = IDX_W'(cnt_q);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: state_d = ST_EVAL;
      ST_EVAL: begin
        if (!flags_ok) begin
          err_d = 1'b1;
        end else if (cmp_agb) begin
          max_d = cmp_a_q;
          idx_d = sidx_q;
        end
`ifdef FP_FRAME_MAX_MIN_EN
        cmp_b_d = min_q;
        state_d = ST_WAIT_MIN;
`else
        state_d = frame_full ? ST_DONE : ST_ACCEPT;
`endif
      end
`ifdef FP_FRAME_MAX_MIN_EN
      ST_WAIT_MIN: state_d = ST_EVAL_MIN;
      ST_EVAL_MIN: begin
        if (!flags_ok) begin
          err_d = 1'b1;
        end else if (cmp_alb) begin
          min_d     = cmp_a_q;
          min_idx_d = sidx_q;
        end
        state_d = frame_full ? ST_DONE : ST_ACCEPT;
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
    in_ready_d  = (state_d == ST_ACCEPT);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCEPT;
      cnt_q       <= '0;
      sidx_q      <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef FP_FRAME_MAX_MIN_EN
      min_q       <= '0;
      min_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sidx_q      <= sidx_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef FP_FRAME_MAX_MIN_EN
      min_q       <= min_d;
      min_idx_q   <= min_idx_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_err   = err_q;
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
`ifdef FP_FRAME_MAX_MIN_EN
  assign out_min     = min_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_fp_frame_max.sv
// tb/tb_fp_frame_max.sv - self-checking bench for fp_frame_max (FRAME_LEN=4 and FRAME_LEN=1)
module tb_fp_frame_max;

  localparam int FL = 4;
  localparam int IW = 2;
`ifdef FP_FRAME_MAX_MIN_EN
  localparam int NONFIRST = 5;
`else
  localparam int NONFIRST = 3;
`endif

  typedef logic [FL-1:0][31:0] frame_t;
  typedef struct {
    frame_t      s;
    int          inj;
    int          hold;
    logic [31:0] emax;
    int          eidx;
    logic        eerr;
    logic [31:0] emin;
    int          emin_idx;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0]   in_data, cmp_a, cmp_b, out_max, out_min;
  logic [IW-1:0] out_idx, out_min_idx;
  logic          aeb = 1'b0, agb = 1'b0, alb = 1'b0;

  logic          in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [31:0]   in_data1, cmp_a1, cmp_b1, out_max1, out_min1;
  logic [0:0]    out_idx1, out_min_idx1;
  logic          zero_flag = 1'b0;

  int n_chk = 0, n_fail = 0;
  int inj_req = 0, inj_ack = 0;
  vec_t tbl [6];

  fp_frame_max #(.FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_aeb(aeb), .cmp_agb(agb), .cmp_alb(alb),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
    .out_err(out_err)
`ifdef FP_FRAME_MAX_MIN_EN
    , .out_min(out_min), .out_min_idx(out_min_idx)
`endif
  );

  fp_frame_max #(.FRAME_LEN(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_aeb(zero_flag), .cmp_agb(zero_flag), .cmp_alb(zero_flag),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_max(out_max1), .out_idx(out_idx1),
    .out_err(out_err1)
`ifdef FP_FRAME_MAX_MIN_EN
    , .out_min(out_min1), .out_min_idx(out_min_idx1)
`endif
  );

`ifndef FP_FRAME_MAX_MIN_EN
  assign out_min      = '0;
  assign out_min_idx  = '0;
  assign out_min1     = '0;
  assign out_min_idx1 = '0;
`endif

  // Sign-magnitude total order: positive beats negative, -0 < +0, NaNs by bit pattern.
  function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  // Registered comparator; an injection request forces one 000 flag set.
  always @(posedge clk) begin
    if (inj_req != inj_ack) begin
      {aeb, agb, alb} <= 3'b000;
      inj_ack <= inj_req;
    end else begin
      aeb <= (cmp_a == cmp_b);
      agb <= fp_gt(cmp_a, cmp_b);
      alb <= fp_gt(cmp_b, cmp_a);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running sim expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input logic [31:0] d, input int inj, input int hold,
                               input logic [31:0] emax, input int eidx, input logic eerr,
                               input logic [31:0] emin, input int emin_idx);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.inj = inj; v.hold = hold; v.emax = emax; v.eidx = eidx; v.eerr = eerr;
    v.emin = emin; v.emin_idx = emin_idx;
    return v;
  endfunction

  task automatic model(input frame_t s, input int inj, output logic [31:0] mx, output int mi,
                       output logic er, output logic [31:0] mn, output int ni);
    mx = s[0]; mi = 0; mn = s[0]; ni = 0; er = 1'b0;
    for (int k = 1; k < FL; k++) begin
      if (k == inj) er = 1'b1;
      else if (fp_gt(s[k], mx)) begin mx = s[k]; mi = k; end
      if (fp_gt(mn, s[k])) begin mn = s[k]; ni = k; end
    end
  endtask

  task automatic send(input logic [31:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input int hold, output logic [31:0] m, output logic [IW-1:0] i,
                      output logic e, output logic [31:0] mn, output logic [IW-1:0] mi);
    int t = 0;
    while (out_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
    m = out_max; i = out_idx; e = out_err; mn = out_min; mi = out_min_idx;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("hold_max", out_max, m);
      chk("hold_idx", 32'(out_idx), 32'(i));
      chk("hold_err", 32'(out_err), 32'(e));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
    chk("handoff_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_frame(input frame_t s, input int inj, input int hold,
                           output logic [31:0] m, output logic [IW-1:0] i, output logic e,
                           output logic [31:0] mn, output logic [IW-1:0] mi);
    for (int k = 0; k < FL; k++) begin
      send(s[k]);
      if (k == inj) inj_req++;
    end
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = 32'h7F7F_FFFF;
    end
    recv(hold, m, i, e, mn, mi);
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] m, input logic [IW-1:0] i,
                           input logic e, input logic [31:0] mn, input logic [IW-1:0] mi,
                           input logic [31:0] emax, input int eidx, input logic eerr,
                           input logic [31:0] emin, input int emin_idx);
    chk({tag, "_max"}, m, emax);
    chk({tag, "_idx"}, 32'(i), 32'(eidx));
    chk({tag, "_err"}, 32'(e), 32'(eerr));
`ifdef FP_FRAME_MAX_MIN_EN
    chk({tag, "_min"}, mn, emin);
    chk({tag, "_min_idx"}, 32'(mi), 32'(emin_idx));
`else
    if (mn !== mn || mi !== mi || emin !== emin || emin_idx != emin_idx) n_fail += 0;
`endif
  endtask

  function automatic logic [31:0] rnd_sample();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h3F80_0000;
      3: return 32'hBF80_0000;
      4: return 32'h7F80_0000;
      5: return 32'hFF80_0000;
      6: return 32'h7FC0_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    frame_t          f;
    logic [31:0]     m, mn, rmax, rmin;
    logic [IW-1:0]   i, mi;
    logic            e, rerr;
    int              ridx, rnidx, lowc, inj, hold;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

    tbl[0] = mkv(32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40400000, -1, 0,
                 32'h40400000, 1, 1'b0, 32'hC0000000, 2);
    tbl[1] = mkv(32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0800000, -1, 5,
                 32'hBF800000, 1, 1'b0, 32'hC0800000, 3);
    tbl[2] = mkv(32'h3F800000, 32'h40000000, 32'h40800000, 32'h3F000000, 2, 0,
                 32'h40000000, 1, 1'b1, 32'h3F000000, 3);
    tbl[3] = mkv(32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, -1, 0,
                 32'h00000000, 1, 1'b0, 32'h80000000, 0);
    tbl[4] = mkv(32'h7FC00000, 32'h7F800000, 32'hFFC00000, 32'h7FC00001, -1, 2,
                 32'h7FC00001, 3, 1'b0, 32'hFFC00000, 2);
    tbl[5] = mkv(32'h41200000, 32'h3F800000, 32'h41200000, 32'hC1200000, -1, 0,
                 32'h41200000, 0, 1'b0, 32'hC1200000, 3);

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_max", out_max, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_cmp_a", cmp_a, 32'd0);
    chk("rst_cmp_b", cmp_b, 32'd0);
    chk("rst_in_ready1", 32'(in_ready1), 32'd0);
    chk("rst_cmp_a1", cmp_a1, 32'd0);
    chk("rst_cmp_b1", cmp_b1, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Cycle timing of one frame: operands, in_ready gap, result latency
    f[0] = 32'h40A00000; f[1] = 32'h40E00000; f[2] = 32'hC1000000; f[3] = 32'h40E00000;
    send(f[0]);
    chk("first_in_ready", 32'(in_ready), 32'd1);
    send(f[1]);
    chk("op_cmp_a", cmp_a, f[1]);
    chk("op_cmp_b", cmp_b, f[0]);
    lowc = 0;
    while (in_ready === 1'b0 && lowc < 10) begin @(posedge clk); #1; lowc++; end
    chk("in_ready_gap", 32'(lowc), 32'(NONFIRST - 1));
    send(f[2]);
    send(f[3]);
    lowc = 0;
    while (out_valid !== 1'b1 && lowc < 10) begin @(posedge clk); #1; lowc++; end
    chk("result_latency", 32'(lowc), 32'(NONFIRST - 1));
    recv(0, m, i, e, mn, mi);
    model(f, -1, rmax, ridx, rerr, rmin, rnidx);
    chk_frame("timing", m, i, e, mn, mi, rmax, ridx, rerr, rmin, rnidx);

    // Directed table
    for (int k = 0; k < 6; k++) begin
      run_frame(tbl[k].s, tbl[k].inj, tbl[k].hold, m, i, e, mn, mi);
      chk_frame($sformatf("tbl%0d", k), m, i, e, mn, mi,
                tbl[k].emax, tbl[k].eidx, tbl[k].eerr, tbl[k].emin, tbl[k].emin_idx);
    end

    // Randomized frames against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < FL; k++) f[k] = rnd_sample();
      if ($urandom_range(0, 3) == 0) f[$urandom_range(0, FL - 1)] = f[$urandom_range(0, FL - 1)];
      inj  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FL - 1)) : -1;
      hold = int'($urandom_range(0, 3));
      run_frame(f, inj, hold, m, i, e, mn, mi);
      model(f, inj, rmax, ridx, rerr, rmin, rnidx);
      chk_frame($sformatf("rnd%0d", r), m, i, e, mn, mi, rmax, ridx, rerr, rmin, rnidx);
    end

    // Reset mid-frame after two samples
    send(32'h42000000);
    send(32'h43000000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_max", out_max, 32'd0);
    chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
    chk("mid_rst_out_err", 32'(out_err), 32'd0);
    chk("mid_rst_cmp_a", cmp_a, 32'd0);
    chk("mid_rst_cmp_b", cmp_b, 32'd0);
`ifdef FP_FRAME_MAX_MIN_EN
    chk("mid_rst_out_min", out_min, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    f[0] = 32'h3F000000; f[1] = 32'h3E800000; f[2] = 32'h3F400000; f[3] = 32'hBF000000;
    run_frame(f, -1, 0, m, i, e, mn, mi);
    model(f, -1, rmax, ridx, rerr, rmin, rnidx);
    chk_frame("after_rst", m, i, e, mn, mi, rmax, ridx, rerr, rmin, rnidx);

    // FRAME_LEN=1 instance
    @(negedge clk);
    chk("fl1_idle_valid", 32'(out_valid1), 32'd0);
    chk("fl1_idle_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1; in_data1 = 32'h80000000;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("fl1_out_valid", 32'(out_valid1), 32'd1);
    chk("fl1_out_max", out_max1, 32'h80000000);
    chk("fl1_out_idx", 32'(out_idx1), 32'd0);
    chk("fl1_out_err", 32'(out_err1), 32'd0);
    chk("fl1_in_ready", 32'(in_ready1), 32'd0);
`ifdef FP_FRAME_MAX_MIN_EN
    chk("fl1_out_min", out_min1, 32'h80000000);
    chk("fl1_out_min_idx", 32'(out_min_idx1), 32'd0);
`endif
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("fl1_handoff_ready", 32'(in_ready1), 32'd1);
    chk("fl1_handoff_valid", 32'(out_valid1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
